// File: rtl/mandel_result_tx_if.sv
// Result-uplink port bundle: pixel result strobes in, UART line and status out.
interface mandel_result_tx_if;
  logic       res_we;
  logic [8:0] px;
  logic [8:0] py;
  logic [7:0] iter;
  logic       fin;
  logic       TXD;
  logic       busy;
  logic       overflow;

  modport master (
    output res_we, px, py, iter, fin,
    input  TXD, busy, overflow
  );

  modport slave (
    input  res_we, px, py, iter, fin,
    output TXD, busy, overflow
  );
endinterface

// File: rtl/mandel_result_tx.sv
// Mandelbrot result uplink: queues {px, py, iter} results and streams them as
// 6-byte framed 8N1 UART packets, followed by a 0x5A end-of-frame marker.
//
// state | meaning
// IDLE  | line idle high; pops the next result or launches a pending marker
// SEND  | serializing packet bytes 0..5 back-to-back
// MARK  | serializing the single 0x5A end marker
module mandel_result_tx #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input logic                clk,
  input logic                rst,
  mandel_result_tx_if.slave  bus
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_MARK} state_t;

  state_t         state_q, state_d;
  logic [25:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           marker_q, marker_d;
  logic           overflow_q, overflow_d;
  logic           busy_q, busy_d;
  logic           txd_q, txd_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [3:0]     bit_idx_q, bit_idx_d;
  logic [2:0]     byte_idx_q, byte_idx_d;
  logic [25:0]    ent_q, ent_d;
  logic [7:0]     chk_q, chk_d;
  logic [7:0]     cur_q, cur_d;
  logic           push, pop;
  logic [25:0]    head;

  function automatic logic [7:0] pkt_byte(input logic [2:0] idx,
                                          input logic [25:0] e,
                                          input logic [7:0] c);
    case (idx)
      3'd0:    pkt_byte = 8'hA5;
      3'd1:    pkt_byte = {6'b0, e[25], e[16]};
      3'd2:    pkt_byte = e[24:17];
      3'd3:    pkt_byte = e[15:8];
      3'd4:    pkt_byte = e[7:0];
      default: pkt_byte = c;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    marker_d   = marker_q;
    overflow_d = overflow_q;
    txd_d      = txd_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    ent_d      = ent_q;
    chk_d      = chk_q;
    cur_d      = cur_q;
    pop        = 1'b0;
    head       = mem_q[rd_ptr_q];

    // Fullness is judged on the registered count, so a same-cycle pop never frees room.
    push = bus.res_we && (count_q < CW'(FIFO_DEPTH));
    if (bus.res_we && !push) overflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          ent_d      = head;
          chk_d      = {6'b0, head[25], head[16]} ^ head[24:17] ^ head[15:8] ^ head[7:0];
          cur_d      = 8'hA5;
          byte_idx_d = 3'd0;
          bit_idx_d  = 4'd0;
          baud_d     = BW'(DIV - 1);
          txd_d      = 1'b0;
          state_d    = ST_SEND;
        end else if (marker_q) begin
          marker_d  = 1'b0;
          cur_d     = 8'h5A;
          bit_idx_d = 4'd0;
          baud_d    = BW'(DIV - 1);
          txd_d     = 1'b0;
          state_d   = ST_MARK;
        end
      end
      ST_SEND, ST_MARK: begin
        if (baud_q != '0) begin
          baud_d = baud_q - BW'(1);
        end else begin
          baud_d = BW'(DIV - 1);
          if (bit_idx_q == 4'd9) begin
            bit_idx_d = 4'd0;
            if (state_q == ST_SEND && byte_idx_q != 3'd5) begin
              byte_idx_d = byte_idx_q + 3'd1;
              cur_d      = pkt_byte(byte_idx_q + 3'd1, ent_q, chk_q);
              txd_d      = 1'b0;
            end else begin
              baud_d  = '0;
              txd_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            txd_d     = (bit_idx_q < 4'd8) ? cur_q[bit_idx_q[2:0]] : 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fin arriving while a marker is pending simply merges into it.
    if (bus.fin) marker_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    busy_d  = (count_d != '0) || (state_d != ST_IDLE) || marker_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      marker_q   <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      txd_q      <= 1'b1;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      ent_q      <= '0;
      chk_q      <= '0;
      cur_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      marker_q   <= marker_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      txd_q      <= txd_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      ent_q      <= ent_d;
      chk_q      <= chk_d;
      cur_q      <= cur_d;
      if (push) mem_q[wr_ptr_q] <= {bus.px, bus.py, bus.iter};
    end
  end

  assign bus.TXD      = txd_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_mandel_result_tx.sv
// Bench for mandel_result_tx: one instance at default baud, one at DIV=8 for long sequences.
module tb_mandel_result_tx;

  localparam int DIV_S = 24000000 / 115200;
  localparam int DIV_F = 8;

  logic clk = 1'b0;
  logic rst_s, rst_f;
  always #5 clk = ~clk;

  mandel_result_tx_if bus_s ();
  mandel_result_tx_if bus_f ();

  mandel_result_tx dut_s (.clk(clk), .rst(rst_s), .bus(bus_s.slave));
  mandel_result_tx #(.CLK_HZ(24000000), .BAUD(3000000), .FIFO_DEPTH(16))
    dut_f (.clk(clk), .rst(rst_f), .bus(bus_f.slave));

  typedef struct packed {
    logic [8:0]  px;
    logic [8:0]  py;
    logic [7:0]  it;
    logic [47:0] bytes;
  } vec_t;

  vec_t vecs [5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic txd(input bit f);
    return f ? bus_f.TXD : bus_s.TXD;
  endfunction
  function automatic logic busy(input bit f);
    return f ? bus_f.busy : bus_s.busy;
  endfunction
  function automatic logic ovf(input bit f);
    return f ? bus_f.overflow : bus_s.overflow;
  endfunction

  function automatic logic [47:0] pkt(input logic [8:0] px, input logic [8:0] py, input logic [7:0] it);
    logic [7:0] b1;
    b1 = {6'b0, px[8], py[8]};
    return {8'hA5, b1, px[7:0], py[7:0], it, b1 ^ px[7:0] ^ py[7:0] ^ it};
  endfunction

  function automatic logic [8:0] bpx(input int i); return 9'(i * 23);      endfunction
  function automatic logic [8:0] bpy(input int i); return 9'(i * 7 + 200); endfunction
  function automatic logic [7:0] bit_(input int i); return 8'(i * 13);     endfunction

  task automatic drive(input bit f, input logic we, input logic [8:0] px, input logic [8:0] py,
                       input logic [7:0] it, input logic fn);
    if (f) begin
      bus_f.res_we = we; bus_f.px = px; bus_f.py = py; bus_f.iter = it; bus_f.fin = fn;
    end else begin
      bus_s.res_we = we; bus_s.px = px; bus_s.py = py; bus_s.iter = it; bus_s.fin = fn;
    end
  endtask

  task automatic send(input bit f, input logic we, input logic [8:0] px, input logic [8:0] py,
                      input logic [7:0] it, input logic fn);
    @(negedge clk) drive(f, we, px, py, it, fn);
    @(negedge clk) drive(f, 1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
  endtask

  task automatic expect_byte(input bit f, input logic [7:0] b, input int pre, input string name);
    int         div;
    int         bad;
    logic [7:0] got;
    logic [9:0] frame;
    logic       v;
    div   = f ? DIV_F : DIV_S;
    bad   = 0;
    got   = '0;
    frame = {1'b1, b, 1'b0};
    for (int c = pre; c < 10 * div; c++) begin
      @(negedge clk);
      v = txd(f);
      if (v !== frame[c / div]) bad++;
      if ((c % div) == div / 2 && (c / div) >= 1 && (c / div) <= 8) got[(c / div) - 1] = v;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s got %02h exp %02h bad_cycles %0d", name, got, b, bad);
    end
  endtask

  task automatic expect_pkt(input bit f, input logic [47:0] p, input int pre, input string name);
    for (int k = 0; k < 6; k++)
      expect_byte(f, p[47 - 8 * k -: 8], (k == 0) ? pre : 0, $sformatf("%s.b%0d", name, k));
  endtask

  task automatic expect_idle(input bit f, input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (txd(f) !== 1'b1) bad++;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  task automatic wait_start(input bit f, input int limit, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (txd(f) === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{9'd5,   9'd3,   8'd100,  48'hA5_00_05_03_64_62};
    vecs[1] = '{9'd300, 9'd257, 8'd0,    48'hA5_03_2C_01_00_2E};
    vecs[2] = '{9'd191, 9'd127, 8'd7,    48'hA5_00_BF_7F_07_C7};
    vecs[3] = '{9'd511, 9'd0,   8'd255,  48'hA5_02_FF_00_FF_02};
    vecs[4] = '{9'd0,   9'd511, 8'h5A,   48'hA5_01_00_FF_5A_A4};

    rst_s = 1'b1;
    rst_f = 1'b1;
    drive(1'b0, 1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("rst%0d.txd", f), 64'(txd(f[0])), 64'd1);
      chk($sformatf("rst%0d.busy", f), 64'(busy(f[0])), 64'd0);
      chk($sformatf("rst%0d.ovf", f), 64'(ovf(f[0])), 64'd0);
    end
    rst_s = 1'b0;
    rst_f = 1'b0;
    repeat (2) @(negedge clk);

    // Single packets from idle on the fast instance
    for (int v = 0; v < 5; v++) begin
      send(1'b1, 1'b1, vecs[v].px, vecs[v].py, vecs[v].it, 1'b0);
      chk($sformatf("v%0d.pre_txd", v), 64'(txd(1'b1)), 64'd1);
      chk($sformatf("v%0d.busy_rise", v), 64'(busy(1'b1)), 64'd1);
      expect_pkt(1'b1, vecs[v].bytes, 0, $sformatf("v%0d", v));
      @(negedge clk);
      chk($sformatf("v%0d.busy_fall", v), 64'(busy(1'b1)), 64'd0);
      chk($sformatf("v%0d.txd_idle", v), 64'(txd(1'b1)), 64'd1);
    end

    // Default baud: single packet with 208-cycle bits
    send(1'b0, 1'b1, vecs[0].px, vecs[0].py, vecs[0].it, 1'b0);
    chk("slow.pre_txd", 64'(txd(1'b0)), 64'd1);
    expect_pkt(1'b0, vecs[0].bytes, 0, "slow.v0");
    @(negedge clk);
    chk("slow.v0.busy_fall", 64'(busy(1'b0)), 64'd0);

    // Default baud: two packets queued back-to-back
    @(negedge clk) drive(1'b0, 1'b1, vecs[1].px, vecs[1].py, vecs[1].it, 1'b0);
    @(negedge clk) drive(1'b0, 1'b1, vecs[2].px, vecs[2].py, vecs[2].it, 1'b0);
    @(negedge clk) drive(1'b0, 1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
    chk("slow.pair.start", 64'(txd(1'b0)), 64'd0);
    expect_pkt(1'b0, vecs[1].bytes, 1, "slow.v1");
    expect_idle(1'b0, 1, "slow.pair.gap");
    chk("slow.pair.gap_busy", 64'(busy(1'b0)), 64'd1);
    expect_pkt(1'b0, vecs[2].bytes, 0, "slow.v2");
    @(negedge clk);
    chk("slow.pair.busy_fall", 64'(busy(1'b0)), 64'd0);

    // Burst of 20 writes: 17 accepted, 3 dropped
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (i == 17) chk("burst.ovf_before", 64'(ovf(1'b1)), 64'd0);
          if (i == 18) chk("burst.ovf_after", 64'(ovf(1'b1)), 64'd1);
          drive(1'b1, 1'b1, bpx(i), bpy(i), bit_(i), 1'b0);
        end
        @(negedge clk) drive(1'b1, 1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
      end
      begin
        bit got_start;
        wait_start(1'b1, 10, "burst.start", got_start);
        if (got_start) begin
          for (int e = 0; e < 17; e++) begin
            expect_pkt(1'b1, pkt(bpx(e), bpy(e), bit_(e)), (e == 0) ? 1 : 0, $sformatf("burst.e%0d", e));
            if (e < 16) expect_idle(1'b1, 1, $sformatf("burst.gap%0d", e));
          end
          @(negedge clk);
          chk("burst.busy_fall", 64'(busy(1'b1)), 64'd0);
          expect_idle(1'b1, 3 * 10 * DIV_F, "burst.no_extra");
        end
      end
    join
    chk("burst.ovf_sticky", 64'(ovf(1'b1)), 64'd1);

    // Three packets, fin during packet 2 and again during packet 3 -> one marker
    fork
      begin
        for (int i = 0; i < 3; i++) @(negedge clk) drive(1'b1, 1'b1, bpx(i + 5), bpy(i + 5), bit_(i + 5), 1'b0);
        @(negedge clk) drive(1'b1, 1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
        repeat (600) @(negedge clk);
        send(1'b1, 1'b0, 9'd0, 9'd0, 8'd0, 1'b1);
        repeat (500) @(negedge clk);
        send(1'b1, 1'b0, 9'd0, 9'd0, 8'd0, 1'b1);
      end
      begin
        bit got_start;
        wait_start(1'b1, 10, "fin.start", got_start);
        if (got_start) begin
          for (int e = 0; e < 3; e++) begin
            expect_pkt(1'b1, pkt(bpx(e + 5), bpy(e + 5), bit_(e + 5)), (e == 0) ? 1 : 0, $sformatf("fin.p%0d", e));
            expect_idle(1'b1, 1, $sformatf("fin.gap%0d", e));
          end
          expect_byte(1'b1, 8'h5A, 0, "fin.marker");
          @(negedge clk);
          chk("fin.busy_fall", 64'(busy(1'b1)), 64'd0);
          expect_idle(1'b1, 12 * 10 * DIV_F, "fin.single_marker");
        end
      end
    join

    // Simultaneous res_we and fin: packet then marker
    send(1'b1, 1'b1, vecs[2].px, vecs[2].py, vecs[2].it, 1'b1);
    chk("wefin.busy_rise", 64'(busy(1'b1)), 64'd1);
    expect_pkt(1'b1, vecs[2].bytes, 0, "wefin");
    expect_idle(1'b1, 1, "wefin.gap");
    expect_byte(1'b1, 8'h5A, 0, "wefin.marker");
    @(negedge clk);
    chk("wefin.busy_fall", 64'(busy(1'b1)), 64'd0);
    chk("pre_rst.ovf", 64'(ovf(1'b1)), 64'd1);

    // Reset mid-byte with 4 queued, coinciding with a res_we
    for (int i = 0; i < 4; i++) @(negedge clk) drive(1'b1, 1'b1, bpx(i), bpy(i), bit_(i), 1'b0);
    @(negedge clk) drive(1'b1, 1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
    repeat (3 * DIV_F) @(negedge clk);
    rst_f = 1'b1;
    drive(1'b1, 1'b1, vecs[3].px, vecs[3].py, vecs[3].it, 1'b0);
    @(negedge clk);
    rst_f = 1'b0;
    drive(1'b1, 1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
    chk("rst.txd", 64'(txd(1'b1)), 64'd1);
    chk("rst.busy", 64'(busy(1'b1)), 64'd0);
    chk("rst.ovf", 64'(ovf(1'b1)), 64'd0);
    expect_idle(1'b1, 20 * DIV_F, "rst.quiet");
    chk("rst.busy_quiet", 64'(busy(1'b1)), 64'd0);
    send(1'b1, 1'b1, vecs[4].px, vecs[4].py, vecs[4].it, 1'b0);
    chk("rst.after.pre_txd", 64'(txd(1'b1)), 64'd1);
    expect_pkt(1'b1, vecs[4].bytes, 0, "rst.after");
    @(negedge clk);
    chk("rst.after.busy_fall", 64'(busy(1'b1)), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
